// File: rtl/key_if.sv
// Pushbutton bundle between the raw KEY pins and the controller-facing
// press/held outputs.
interface key_if;
  logic [3:0] KEY;
  logic [3:0] press;
  logic [3:0] held;

  modport master (output KEY, input press, input held);
  modport slave  (input KEY, output press, output held);
endinterface

// File: rtl/key_conditioner.sv
// Synchronises, debounces and edge-detects four active-low pushbuttons and
// emits at most one one-hot press pulse per clock, with optional auto-repeat.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  key_if.slave       bus,
  output logic [7:0] dbg_rpt_state
);

  localparam logic [1:0] RS_IDLE   = 2'd0;
  localparam logic [1:0] RS_DELAY  = 2'd1;
  localparam logic [1:0] RS_PERIOD = 2'd2;

  localparam bit               RPT_EN   = (REPEAT_DELAY != 0);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = RPT_EN ? CNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [3:0]       sync1, sync2;
  logic [3:0]       stable;
  logic [3:0]       held_r;
  logic [3:0]       press_r;
  logic [3:0]       edge_req;
  logic [3:0]       rpt_hit;
  logic [3:0]       req;
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] rpt [4];
  logic [1:0]       rs  [4];

  // Synchroniser stores the inverted (active-high) level; reset = released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~bus.KEY;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        cnt[i]    <= '0;
        stable[i] <= 1'b0;
      end else if (sync2[i] == stable[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == DEB_LAST) begin
        cnt[i]    <= '0;
        stable[i] <= sync2[i];
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Repeat state per key: DELAY until the first repeat, then PERIOD.
  // The counter restarts at every hit and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || !RPT_EN || !stable[i]) begin
        rs[i]  <= RS_IDLE;
        rpt[i] <= '0;
      end else if (!held_r[i]) begin
        rs[i]  <= RS_DELAY;
        rpt[i] <= '0;
      end else begin
        case (rs[i])
          RS_DELAY: begin
            if (rpt[i] == DLY_LAST) begin
              rs[i]  <= RS_PERIOD;
              rpt[i] <= '0;
            end else if (rpt[i] != '1) begin
              rpt[i] <= rpt[i] + 1'b1;
            end
          end
          RS_PERIOD: begin
            if (rpt[i] == PER_LAST) begin
              rpt[i] <= '0;
            end else if (rpt[i] != '1) begin
              rpt[i] <= rpt[i] + 1'b1;
            end
          end
          default: begin
            rs[i]  <= RS_IDLE;
            rpt[i] <= '0;
          end
        endcase
      end
    end
  end

  // held_r is stable delayed by one cycle, so it doubles as the edge reference.
  always_comb begin
    edge_req = stable & ~held_r;
    rpt_hit  = '0;
    for (int i = 0; i < 4; i++) begin
      rpt_hit[i] = RPT_EN && stable[i] && held_r[i] &&
                   ((rs[i] == RS_DELAY  && rpt[i] == DLY_LAST) ||
                    (rs[i] == RS_PERIOD && rpt[i] == PER_LAST));
    end
    req = edge_req | rpt_hit;
  end

  // Lowest-index request wins; the rest are dropped this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_r <= '0;
      held_r  <= '0;
    end else begin
      press_r <= req & (~req + 4'd1);
      held_r  <= stable;
    end
  end

  assign bus.press     = press_r;
  assign bus.held      = held_r;
  assign dbg_rpt_state = {rs[3], rs[2], rs[1], rs[0]};

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: debounce/no-repeat instance (a) and an
// auto-repeat instance (b), both with DEBOUNCE_CYCLES=4.
module tb_key_conditioner;

  logic clk;
  logic rst_n_a, rst_n_b;
  logic [7:0] dbg_a, dbg_b;
  int   cyc;
  int   total, bad;
  bit   mon_on;

  logic [35:0] q_a[$];
  logic [35:0] q_b[$];

  key_if bus_a ();
  key_if bus_b ();

  key_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3), .CNT_W(24))
    dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a.slave), .dbg_rpt_state(dbg_a));

  key_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(24))
    dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b.slave), .dbg_rpt_state(dbg_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] lowest(input logic [3:0] m);
    lowest = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        lowest = 4'(1 << i);
        break;
      end
    end
  endfunction

  // press pulse expected 7 negedge samples after the drive point
  task automatic expect_a(input int drive_cyc, input logic [3:0] p);
    q_a.push_back({32'(drive_cyc + 7), p});
  endtask

  // scoreboard monitors: every nonzero press must match the queue head
  always @(negedge clk) begin
    if (mon_on && bus_a.press !== 4'b0000) begin
      if (q_a.size() == 0) chk("press_a_unexpected", {32'(cyc), bus_a.press}, 36'd0);
      else chk("press_a", {32'(cyc), bus_a.press}, q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mon_on && bus_b.press !== 4'b0000) begin
      if (q_b.size() == 0) chk("press_b_unexpected", {32'(cyc), bus_b.press}, 36'd0);
      else chk("press_b", {32'(cyc), bus_b.press}, q_b.pop_front());
    end
  end

  typedef struct {
    logic [3:0] key;
    int         hold;
    logic [3:0] exp_press;
    logic [3:0] exp_held;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, m;
    logic [3:0] mask;

    vecs[0] = '{4'b1110, 20, 4'b0001, 4'b0001};
    vecs[1] = '{4'b1111, 20, 4'b0000, 4'b0000};
    vecs[2] = '{4'b0011, 20, 4'b0100, 4'b1100};
    vecs[3] = '{4'b1111, 20, 4'b0000, 4'b0000};
    vecs[4] = '{4'b1101, 20, 4'b0010, 4'b0010};
    vecs[5] = '{4'b0101, 20, 4'b1000, 4'b1010};
    vecs[6] = '{4'b1111, 20, 4'b0000, 4'b0000};

    cyc = 0; total = 0; bad = 0; mon_on = 0;
    rst_n_a = 0; rst_n_b = 0;
    bus_a.KEY = 4'hF; bus_b.KEY = 4'hF;
    step(3);
    chk("reset_press_a", bus_a.press, 0);
    chk("reset_held_a", bus_a.held, 0);
    chk("reset_press_b", bus_b.press, 0);
    chk("reset_held_b", bus_b.held, 0);
    chk("reset_dbg_b", dbg_b, 0);
    rst_n_a = 1; rst_n_b = 1; mon_on = 1;
    step(2);

    // table-driven vectors on instance a
    for (int v = 0; v < 7; v++) begin
      bus_a.KEY = vecs[v].key;
      if (vecs[v].exp_press != 0) expect_a(cyc, vecs[v].exp_press);
      step(vecs[v].hold);
      chk($sformatf("vec%0d_held", v), bus_a.held, vecs[v].exp_held);
    end

    // random multi-key presses from released
    for (int r = 0; r < 4; r++) begin
      mask = 4'($urandom_range(1, 15));
      bus_a.KEY = ~mask;
      expect_a(cyc, lowest(mask));
      step(20);
      chk("rand_held", bus_a.held, mask);
      bus_a.KEY = 4'hF;
      step(20);
      chk("rand_release", bus_a.held, 0);
    end

    // exact held timing on press and release
    bus_a.KEY = 4'b1110;
    expect_a(cyc, 4'b0001);
    step(6); chk("held_rise_early", bus_a.held, 4'b0000);
    step(1); chk("held_rise", bus_a.held, 4'b0001);
    step(13);
    bus_a.KEY = 4'hF;
    step(6); chk("held_fall_early", bus_a.held, 4'b0001);
    step(1); chk("held_fall", bus_a.held, 4'b0000);
    step(13);

    // bounce on KEY[1], one press after the final transition
    bus_a.KEY = 4'b1101; step(2);
    bus_a.KEY = 4'b1111; step(2);
    bus_a.KEY = 4'b1101; step(2);
    bus_a.KEY = 4'b1111; step(2);
    bus_a.KEY = 4'b1101;
    expect_a(cyc, 4'b0010);
    step(20);
    chk("bounce_held", bus_a.held, 4'b0010);
    bus_a.KEY = 4'hF; step(20);

    // 3-cycle glitch on KEY[2] is rejected
    bus_a.KEY = 4'b1011; step(3);
    bus_a.KEY = 4'hF;
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("glitch_held", bus_a.held, 4'b0000);
    end

    // reset while cnt[0] == 2, key still held
    bus_a.KEY = 4'b1110;
    step(4);
    rst_n_a = 0;
    step(1);
    chk("midrst_held", bus_a.held, 0);
    chk("midrst_press", bus_a.press, 0);
    rst_n_a = 1;
    expect_a(cyc, 4'b0001);
    step(20);
    bus_a.KEY = 4'hF; step(20);

    // auto-repeat on instance b: KEY[0] held 30 cycles
    n = cyc;
    bus_b.KEY = 4'b1110;
    q_b.push_back({32'(n + 7), 4'b0001});
    for (int c = n + 17; c <= n + 35; c += 3) q_b.push_back({32'(c), 4'b0001});
    step(30);
    bus_b.KEY = 4'hF;
    step(25);
    chk("rpt_released_held", bus_b.held, 0);

    // simultaneous repeats on KEY[1] and KEY[3]: only KEY[1] is seen
    m = cyc;
    bus_b.KEY = 4'b0101;
    q_b.push_back({32'(m + 7), 4'b0010});
    q_b.push_back({32'(m + 17), 4'b0010});
    q_b.push_back({32'(m + 20), 4'b0010});
    q_b.push_back({32'(m + 23), 4'b0010});
    step(18);
    chk("rpt2_held", bus_b.held, 4'b1010);
    bus_b.KEY = 4'hF;
    step(25);

    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
